seg_display_arbiter: RTL and testbench

//  Owns the 4-digit 7-segment display and shares it between two sources: the scrolling-text

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_timer.sv | 36 +++
 rtl/seg_display_arbiter.sv | 143 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display arbiter and scan timer.
package seg_pkg;

  typedef enum logic [1:0] {
    MAIN  = 2'd0,
    PEND  = 2'd1,
    OVL   = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Pick the segment byte for one digit; [7:0] is digit0 ... [31:24] is digit3.
  function automatic logic [7:0] digit_byte(input logic [31:0] data, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan timebase: slot counter, digit index, anti-ghost blank window and frame-boundary pulse.
module seg_scan_timer #(
  parameter int unsigned SCAN_DIV     = 32767,
  parameter int unsigned BLANK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] idx,
  output logic       slot_start_c,
  output logic       blank_c,
  output logic       fb_c
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV);
  localparam logic [SLOT_W-1:0] BLANK_END  = SLOT_W'(BLANK_CYCLES);

  logic [SLOT_W-1:0] slot_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign slot_start_c = (slot_cnt == '0);
  assign blank_c      = (slot_cnt < BLANK_END);
  assign fb_c         = (idx == 2'd3) && (slot_cnt == SLOT_LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 4-digit 7-segment display between the main datapath and a timed overlay,
// switching sources only on frame boundaries.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 32767,
  parameter int unsigned BLANK_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES  = 24000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] main_data,
  input  logic        ovl_req,
  input  logic [31:0] ovl_data,
  input  logic        ovl_cancel,
  output logic        ovl_ack,
  output logic        ovl_busy,
  output logic        src_sel,
  output logic [7:0]  out_digit,
  output logic [3:0]  out_ans
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        idx;
  logic              slot_start_c;
  logic              blank_c;
  logic              fb_c;

  arb_state_e        state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              upd_pend, upd_d;
  logic              src_d;
  logic              load_cur_c;
  logic [31:0]       ovl_next;
  logic [31:0]       ovl_cur;
  logic [7:0]        seg_byte;
  logic [7:0]        sel_byte_c;
  logic [7:0]        byte_c;

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx          (idx),
    .slot_start_c (slot_start_c),
    .blank_c      (blank_c),
    .fb_c         (fb_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MAIN;
      hold_cnt <= '0;
      upd_pend <= 1'b0;
      src_sel  <= 1'b0;
      ovl_next <= '0;
      ovl_cur  <= '0;
      ovl_ack  <= 1'b0;
      ovl_busy <= 1'b0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_d;
      upd_pend <= upd_d;
      src_sel  <= src_d;
      ovl_ack  <= ovl_req;
      ovl_busy <= (state_d != MAIN);
      if (ovl_req)    ovl_next <= ovl_data;
      if (load_cur_c) ovl_cur  <= ovl_next;
    end
  end

  // A new request always wins over cancel; source and overlay data only move at fb.
  always_comb begin
    state_d    = state;
    hold_d     = hold_cnt;
    upd_d      = upd_pend;
    src_d      = src_sel;
    load_cur_c = 1'b0;
    case (state)
      MAIN: begin
        if (ovl_req) state_d = PEND;
      end
      PEND: begin
        if (ovl_req) begin
          state_d = PEND;
        end else if (ovl_cancel) begin
          state_d = MAIN;
        end else if (fb_c) begin
          state_d    = OVL;
          hold_d     = '0;
          src_d      = 1'b1;
          load_cur_c = 1'b1;
        end
      end
      OVL: begin
        hold_d = hold_cnt + HOLD_W'(1);
        if (fb_c && upd_pend) begin
          load_cur_c = 1'b1;
          upd_d      = 1'b0;
        end
        if (ovl_req) begin
          hold_d = '0;
          upd_d  = 1'b1;
        end else if (ovl_cancel || (hold_cnt == HOLD_LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ovl_req) begin
          state_d = OVL;
          hold_d  = '0;
          upd_d   = 1'b1;
        end else if (fb_c) begin
          state_d = MAIN;
          src_d   = 1'b0;
          upd_d   = 1'b0;
        end
      end
      default: state_d = MAIN;
    endcase
  end

  // Slot byte is frozen at slot start; bypass keeps slot 0 correct even without a blank gap.
  assign sel_byte_c = digit_byte(src_sel ? ovl_cur : main_data, idx);
  assign byte_c     = slot_start_c ? sel_byte_c : seg_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_byte  <= '0;
      out_digit <= SEG_OFF;
      out_ans   <= AN_OFF;
    end else begin
      if (slot_start_c) seg_byte <= sel_byte_c;
      out_digit <= blank_c ? SEG_OFF : ~byte_c;
      out_ans   <= blank_c ? AN_OFF : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a short scan (8-cycle slots, 32-cycle frames).
module tb_seg_display_arbiter;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] main_data;
  logic        ovl_req;
  logic [31:0] ovl_data;
  logic        ovl_cancel;
  logic        ovl_ack;
  logic        ovl_busy;
  logic        src_sel;
  logic [7:0]  out_digit;
  logic [3:0]  out_ans;

  seg_display_arbiter #(
    .SCAN_DIV     (7),
    .BLANK_CYCLES (2),
    .HOLD_CYCLES  (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .main_data  (main_data),
    .ovl_req    (ovl_req),
    .ovl_data   (ovl_data),
    .ovl_cancel (ovl_cancel),
    .ovl_ack    (ovl_ack),
    .ovl_busy   (ovl_busy),
    .src_sel    (src_sel),
    .out_digit  (out_digit),
    .out_ans    (out_ans)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] main;
    logic [3:0]  ans;
    logic [7:0]  dig;
  } vec_t;

  vec_t       vecs [64];
  logic [3:0] ans_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] dig_a   [4] = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] dig_b   [4] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};

  int tests = 0;
  int fails = 0;
  int pos = 0;
  int ecount = 0;
  int e0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // pos is the frame position (idx*8+slot_cnt) the DUT holds before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
    pos = (pos + 1) % 32;
  endtask

  task automatic tick_to(input int p);
    for (int k = 0; k < 40 && pos != p; k++) tick();
  endtask

  task automatic tick_until(input int target);
    while (ecount < target) tick();
  endtask

  task automatic enter_ovl(input logic [31:0] data);
    ovl_req  = 1'b1;
    ovl_data = data;
    tick();
    ovl_req  = 1'b0;
    tick_to(0);
    e0 = ecount;
  endtask

  initial begin
    rst_n = 1'b0;
    main_data = 32'h0102_0408;
    ovl_req = 1'b0;
    ovl_data = '0;
    ovl_cancel = 1'b0;

    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++)
        for (int s = 0; s < 8; s++) begin
          vecs[f*32 + d*8 + s].main = (f == 0) ? 32'h0102_0408 : 32'h3F06_5B4F;
          vecs[f*32 + d*8 + s].ans  = (s < 2) ? 4'hF : ans_tab[d];
          vecs[f*32 + d*8 + s].dig  = (s < 2) ? 8'hFF : ((f == 0) ? dig_a[d] : dig_b[d]);
        end

    #12;
    check("rst_digit", 32'(out_digit), 32'hFF);
    check("rst_ans", 32'(out_ans), 32'hF);
    check("rst_flags", {29'd0, ovl_ack, ovl_busy, src_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan: two frames of main data
    for (int i = 0; i < 64; i++) begin
      main_data = vecs[i].main;
      tick();
      check($sformatf("scan_ans[%0d]", i), 32'(out_ans), 32'(vecs[i].ans));
      check($sformatf("scan_dig[%0d]", i), 32'(out_digit), 32'(vecs[i].dig));
    end
    main_data = 32'h0102_0408;

    // Overlay basic
    tick_to(10);
    ovl_req = 1'b1;
    ovl_data = 32'hAAAA_AAAA;
    tick();
    ovl_req = 1'b0;
    check("ovl_ack", 32'(ovl_ack), 32'd1);
    check("ovl_busy", 32'(ovl_busy), 32'd1);
    check("ovl_src_pend", 32'(src_sel), 32'd0);
    check("ovl_state_pend", 32'(dut.state), 32'(PEND));
    tick();
    check("ovl_ack_drop", 32'(ovl_ack), 32'd0);
    tick_to(31);
    check("ovl_src_prefb", 32'(src_sel), 32'd0);
    tick();
    e0 = ecount;
    check("ovl_src_fb", 32'(src_sel), 32'd1);
    tick_to(6);
    check("ovl_dig0", 32'(out_digit), 32'h55);
    check("ovl_ans0", 32'(out_ans), 32'hE);
    tick_to(30);
    check("ovl_dig3", 32'(out_digit), 32'h55);
    tick_until(e0 + 99);
    check("ovl_hold_ovl", 32'(dut.state), 32'(OVL));
    tick();
    check("ovl_hold_drain", 32'(dut.state), 32'(DRAIN));
    tick_until(e0 + 127);
    check("ovl_drain_src", 32'(src_sel), 32'd1);
    check("ovl_drain_busy", 32'(ovl_busy), 32'd1);
    tick();
    check("ovl_end_src", 32'(src_sel), 32'd0);
    check("ovl_end_busy", 32'(ovl_busy), 32'd0);
    tick_to(6);
    check("ovl_main_back", 32'(out_digit), 32'hF7);

    // Retrigger at hold_cnt=50
    tick_to(3);
    enter_ovl(32'hAAAA_AAAA);
    tick_until(e0 + 50);
    ovl_req = 1'b1;
    ovl_data = 32'h0F0F_0F0F;
    tick();
    ovl_req = 1'b0;
    check("rt_ack", 32'(ovl_ack), 32'd1);
    check("rt_state", 32'(dut.state), 32'(OVL));
    check("rt_hold", 32'(dut.hold_cnt), 32'd0);
    tick_to(22);
    check("rt_old_dig", 32'(out_digit), 32'h55);
    check("rt_old_ans", 32'(out_ans), 32'hB);
    tick_to(6);
    check("rt_new_dig", 32'(out_digit), 32'hF0);
    tick_until(e0 + 150);
    check("rt_hold_ovl", 32'(dut.state), 32'(OVL));
    tick();
    check("rt_hold_drain", 32'(dut.state), 32'(DRAIN));
    tick_until(e0 + 159);
    check("rt_src_late", 32'(src_sel), 32'd1);
    tick();
    check("rt_src_end", 32'(src_sel), 32'd0);

    // Cancel while pending
    tick_to(5);
    ovl_req = 1'b1;
    ovl_data = 32'h1234_5678;
    tick();
    ovl_req = 1'b0;
    ovl_cancel = 1'b1;
    tick();
    ovl_cancel = 1'b0;
    check("cp_busy", 32'(ovl_busy), 32'd0);
    check("cp_state", 32'(dut.state), 32'(MAIN));
    tick_to(0);
    check("cp_src", 32'(src_sel), 32'd0);

    // Cancel while shown
    tick_to(3);
    enter_ovl(32'hAAAA_AAAA);
    check("co_src_on", 32'(src_sel), 32'd1);
    tick_to(10);
    ovl_cancel = 1'b1;
    tick();
    ovl_cancel = 1'b0;
    check("co_state", 32'(dut.state), 32'(DRAIN));
    tick_to(31);
    check("co_src_hold", 32'(src_sel), 32'd1);
    tick();
    check("co_src_off", 32'(src_sel), 32'd0);
    check("co_busy_off", 32'(ovl_busy), 32'd0);

    // Request and cancel together while shown
    tick_to(3);
    enter_ovl(32'hAAAA_AAAA);
    tick_to(20);
    ovl_req = 1'b1;
    ovl_cancel = 1'b1;
    ovl_data = 32'h5A5A_5A5A;
    tick();
    ovl_req = 1'b0;
    ovl_cancel = 1'b0;
    check("rc_ack", 32'(ovl_ack), 32'd1);
    check("rc_state", 32'(dut.state), 32'(OVL));
    check("rc_hold", 32'(dut.hold_cnt), 32'd0);
    tick();
    check("rc_hold_inc", 32'(dut.hold_cnt), 32'd1);

    // Async reset mid-slot with everything active
    ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    check("pre_rst_digit", 32'(out_ans), 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_digit", 32'(out_digit), 32'hFF);
    check("arst_ans", 32'(out_ans), 32'hF);
    check("arst_flags", {29'd0, ovl_ack, ovl_busy, src_sel}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
